// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard scoreboard driving PC, IF/ID and ID/EX stall/flush
// Optional stall-cycle perf counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int REG_W    = 4,
    parameter int WB_DIST  = 2,
    parameter int FLAG_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_hold,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_flag_en,
    input  logic             id_branch,
    input  logic             id_br,
    input  logic             id_hlt,
    input  logic             update_pc,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_flush,
    output logic             if_flush,
    output logic [31:0]      perf_lu_cnt,
    output logic [31:0]      perf_br_cnt
);

    localparam int NREG = 2 ** REG_W;
    localparam int CW   = $clog2(WB_DIST + 1);
    localparam int FW   = $clog2(FLAG_LAT + 1);
    localparam logic [CW-1:0] WB_INIT = CW'(WB_DIST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [FW-1:0] FL_INIT = FW'(FLAG_LAT);
    localparam logic [FW-1:0] FL_ONE  = FW'(1);

    logic [NREG-1:0][CW-1:0] cnt;
    logic [NREG-1:0]         ld;
    logic [FW-1:0]           flag_cnt;

    logic rs_lu;
    logic rt_lu;
    logic lu_haz;
    logic fl_haz;
    logic br_haz;
    logic hazard;
    logic issue;

    // A load is in EX exactly when its counter still holds the freshly loaded value.
    always_comb begin
        rs_lu  = id_rs_used && (id_rs != '0) && ld[id_rs] && (cnt[id_rs] == WB_INIT);
        rt_lu  = id_rt_used && !id_mem_write && (id_rt != '0) && ld[id_rt] &&
                 (cnt[id_rt] == WB_INIT);
        lu_haz = id_valid && (rs_lu || rt_lu);
        fl_haz = id_valid && id_branch && (flag_cnt != '0);
        br_haz = id_valid && id_branch && id_br && (id_rs != '0) && (cnt[id_rs] != '0);
        hazard = lu_haz || fl_haz || br_haz;
    end

    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        id_flush    = 1'b0;
        if_flush    = 1'b0;
        if (pipe_hold) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
        end else begin
            if_id_stall = id_hlt || hazard;
            pc_stall    = id_hlt || hazard;
            id_flush    = hazard;
            if_flush    = update_pc && !(id_hlt || hazard);
        end
    end

    assign issue = id_valid && !if_id_stall && !pipe_hold;

    // A new writer reloads its register's counter in place of the decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            ld       <= '0;
            flag_cnt <= '0;
        end else if (!pipe_hold) begin
            for (int r = 0; r < NREG; r++) begin
                if (issue && id_reg_write && (id_rd != '0) && (id_rd == REG_W'(r))) begin
                    cnt[r] <= WB_INIT;
                    ld[r]  <= id_mem_read;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                    if (cnt[r] == CNT_ONE) begin
                        ld[r] <= 1'b0;
                    end
                end
            end
            if (issue && id_flag_en) begin
                flag_cnt <= FL_INIT;
            end else if (flag_cnt != '0) begin
                flag_cnt <= flag_cnt - FL_ONE;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] lu_q;
    logic [31:0] br_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lu_q <= '0;
            br_q <= '0;
        end else begin
            if (lu_haz && !pipe_hold && (lu_q != '1)) begin
                lu_q <= lu_q + 32'd1;
            end
            if ((fl_haz || br_haz) && !pipe_hold && (br_q != '1)) begin
                br_q <= br_q + 32'd1;
            end
        end
    end

    assign perf_lu_cnt = lu_q;
    assign perf_br_cnt = br_q;
`else
    assign perf_lu_cnt = 32'h0;
    assign perf_br_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    localparam int REG_W    = 4;
    localparam int WB_DIST  = 2;
    localparam int FLAG_LAT = 1;

    localparam logic [3:0] S_NONE  = 4'b0000;
    localparam logic [3:0] S_STALL = 4'b1110;
    localparam logic [3:0] S_HOLD  = 4'b1100;
    localparam logic [3:0] S_IFF   = 4'b0001;

    typedef struct packed {
        logic             rst;
        logic             hold;
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             rs_used;
        logic             rt_used;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             flag_en;
        logic             branch;
        logic             br;
        logic             hlt;
        logic             upd;
    } stim_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pipe_hold = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic             id_rs_used = 1'b0;
    logic             id_rt_used = 1'b0;
    logic [REG_W-1:0] id_rd = '0;
    logic             id_reg_write = 1'b0;
    logic             id_mem_read = 1'b0;
    logic             id_mem_write = 1'b0;
    logic             id_flag_en = 1'b0;
    logic             id_branch = 1'b0;
    logic             id_br = 1'b0;
    logic             id_hlt = 1'b0;
    logic             update_pc = 1'b0;
    logic             pc_stall;
    logic             if_id_stall;
    logic             id_flush;
    logic             if_flush;
    logic [31:0]      perf_lu_cnt;
    logic [31:0]      perf_br_cnt;
    logic [3:0]       outs;

    int passed = 0;
    int total  = 0;

    stim_t      stim_q[$];
    logic [3:0] exp_q[$];

    assign outs = {pc_stall, if_id_stall, id_flush, if_flush};

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_W   (REG_W),
        .WB_DIST (WB_DIST),
        .FLAG_LAT(FLAG_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_hold   (pipe_hold),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .id_mem_read (id_mem_read),
        .id_mem_write(id_mem_write),
        .id_flag_en  (id_flag_en),
        .id_branch   (id_branch),
        .id_br       (id_br),
        .id_hlt      (id_hlt),
        .update_pc   (update_pc),
        .pc_stall    (pc_stall),
        .if_id_stall (if_id_stall),
        .id_flush    (id_flush),
        .if_flush    (if_flush),
        .perf_lu_cnt (perf_lu_cnt),
        .perf_br_cnt (perf_br_cnt)
    );

    function automatic stim_t s_idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t s_alu(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
        stim_t s;
        s           = '0;
        s.valid     = 1'b1;
        s.reg_write = 1'b1;
        s.rd        = rd;
        s.rs        = rs;
        s.rs_used   = (rs != '0);
        return s;
    endfunction

    function automatic stim_t s_lw(input logic [REG_W-1:0] rd);
        stim_t s;
        s          = s_alu(rd, 4'd1);
        s.mem_read = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_br(input logic [REG_W-1:0] rs);
        stim_t s;
        s         = '0;
        s.valid   = 1'b1;
        s.branch  = 1'b1;
        s.br      = 1'b1;
        s.rs      = rs;
        s.rs_used = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_b();
        stim_t s;
        s        = '0;
        s.valid  = 1'b1;
        s.branch = 1'b1;
        return s;
    endfunction

    task automatic push(input stim_t s, input logic [3:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic push_n(input stim_t s, input logic [3:0] e, input int n);
        for (int k = 0; k < n; k++) push(s, e);
    endtask

    task automatic drain();
        push_n(s_idle(), S_NONE, WB_DIST + FLAG_LAT + 1);
    endtask

    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        rst          = s.rst;
        pipe_hold    = s.hold;
        id_valid     = s.valid;
        id_rs        = s.rs;
        id_rt        = s.rt;
        id_rs_used   = s.rs_used;
        id_rt_used   = s.rt_used;
        id_rd        = s.rd;
        id_reg_write = s.reg_write;
        id_mem_read  = s.mem_read;
        id_mem_write = s.mem_write;
        id_flag_en   = s.flag_en;
        id_branch    = s.branch;
        id_br        = s.br;
        id_hlt       = s.hlt;
        update_pc    = s.upd;
    endtask

    task automatic test_reset();
        stim_t s;
        logic [3:0] e;
        int n;
        s = s_idle();
        s.rst = 1'b1;
        push_n(s, S_NONE, 2);
        push(s_idle(), S_NONE);
        s = s_idle();
        s.valid = 1'b1;
        s.hlt = 1'b1;
        push(s, S_HOLD);
        s.upd = 1'b1;
        push(s, S_HOLD);
        s = s_idle();
        s.upd = 1'b1;
        push(s, S_IFF);
        push(s_idle(), S_NONE);
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs !== e) $display("FAIL reset cycle %0d: outs=%b expected %b", i, outs, e);
            else passed++;
        end
        total++;
        if (perf_lu_cnt !== 32'd0 || perf_br_cnt !== 32'd0)
            $display("FAIL reset_perf: lu=%0d br=%0d expected 0 0", perf_lu_cnt, perf_br_cnt);
        else passed++;
    endtask

    task automatic test_load_use();
        stim_t s;
        logic [3:0] e;
        int n;
        push(s_lw(4'd3), S_NONE);
        s = s_alu(4'd4, 4'd3);
        s.upd = 1'b1;
        push(s, S_STALL);
        push(s_alu(4'd4, 4'd3), S_NONE);
        drain();
        push(s_lw(4'd3), S_NONE);
        s = s_idle();
        s.valid = 1'b1;
        s.mem_write = 1'b1;
        s.rt = 4'd3;
        s.rt_used = 1'b1;
        s.rs = 4'd1;
        s.rs_used = 1'b1;
        push(s, S_NONE);
        push(s_lw(4'd3), S_NONE);
        s.rs = 4'd3;
        push(s, S_STALL);
        push(s, S_NONE);
        drain();
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs !== e) $display("FAIL load_use cycle %0d: outs=%b expected %b", i, outs, e);
            else passed++;
        end
    endtask

    task automatic test_br_dep();
        stim_t s;
        logic [3:0] e;
        int n;
        push(s_alu(4'd5, 4'd0), S_NONE);
        push_n(s_br(4'd5), S_STALL, WB_DIST);
        push(s_br(4'd5), S_NONE);
        drain();
        push(s_alu(4'd5, 4'd0), S_NONE);
        s = s_b();
        s.rs = 4'd5;
        push(s, S_NONE);
        push(s_br(4'd0), S_NONE);
        drain();
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs !== e) $display("FAIL br_dep cycle %0d: outs=%b expected %b", i, outs, e);
            else passed++;
        end
    endtask

    task automatic test_flags();
        stim_t s;
        logic [3:0] e;
        int n;
        s = s_idle();
        s.valid = 1'b1;
        s.flag_en = 1'b1;
        push(s, S_NONE);
        push_n(s_b(), S_STALL, FLAG_LAT);
        push(s_b(), S_NONE);
        drain();
        push(s_b(), S_NONE);
        drain();
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs !== e) $display("FAIL flags cycle %0d: outs=%b expected %b", i, outs, e);
            else passed++;
        end
    endtask

    task automatic test_pipe_hold();
        stim_t s;
        logic [3:0] e;
        int n;
        push(s_alu(4'd5, 4'd0), S_NONE);
        push(s_br(4'd5), S_STALL);
        s = s_br(4'd5);
        s.hold = 1'b1;
        push_n(s, S_HOLD, 3);
        s.upd = 1'b1;
        push(s, S_HOLD);
        push_n(s_br(4'd5), S_STALL, WB_DIST - 1);
        push(s_br(4'd5), S_NONE);
        drain();
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs !== e) $display("FAIL pipe_hold cycle %0d: outs=%b expected %b", i, outs, e);
            else passed++;
        end
    endtask

    task automatic test_rst_mid_stall();
        stim_t s;
        logic [3:0] e;
        int n;
        push(s_alu(4'd5, 4'd0), S_NONE);
        push(s_br(4'd5), S_STALL);
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs !== e) $display("FAIL rst_mid cycle %0d: outs=%b expected %b", i, outs, e);
            else passed++;
        end
        s = s_br(4'd5);
        s.rst = 1'b1;
        apply(s);
        apply(s_br(4'd5));
        @(negedge clk);
        total++;
        if (outs !== S_NONE) $display("FAIL rst_mid_after: outs=%b expected %b", outs, S_NONE);
        else passed++;
        apply(s_idle());
    endtask

    task automatic test_perf();
        stim_t s;
        logic [3:0] e;
        logic [31:0] exp_lu;
        logic [31:0] exp_br;
        int n;
        s = s_idle();
        s.rst = 1'b1;
        push(s, S_NONE);
        push(s_lw(4'd3), S_NONE);
        s = s_alu(4'd4, 4'd3);
        s.hold = 1'b1;
        push_n(s, S_HOLD, 2);
        push(s_alu(4'd4, 4'd3), S_STALL);
        push(s_alu(4'd4, 4'd3), S_NONE);
        push(s_lw(4'd6), S_NONE);
        s = s_alu(4'd7, 4'd0);
        s.rt = 4'd6;
        s.rt_used = 1'b1;
        push(s, S_STALL);
        push(s, S_NONE);
        push(s_lw(4'd2), S_NONE);
        push(s_alu(4'd8, 4'd2), S_STALL);
        push(s_alu(4'd8, 4'd2), S_NONE);
        push(s_alu(4'd5, 4'd0), S_NONE);
        push_n(s_br(4'd5), S_STALL, WB_DIST);
        push(s_br(4'd5), S_NONE);
        drain();
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs !== e) $display("FAIL perf_seq cycle %0d: outs=%b expected %b", i, outs, e);
            else passed++;
        end
`ifdef HAZ_PERF_CNT_EN
        exp_lu = 32'd3;
        exp_br = 32'(WB_DIST);
`else
        exp_lu = 32'd0;
        exp_br = 32'd0;
`endif
        total++;
        if (perf_lu_cnt !== exp_lu) $display("FAIL perf_lu: got %0d expected %0d", perf_lu_cnt, exp_lu);
        else passed++;
        total++;
        if (perf_br_cnt !== exp_br) $display("FAIL perf_br: got %0d expected %0d", perf_br_cnt, exp_br);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_br_dep();
        test_flags();
        test_pipe_hold();
        test_rst_mid_stall();
        test_perf();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the ID-stage hazard logic. It replaces the purely comparator-based EX/MEM destination checks with a per-register write-pending scoreboard and a flag-pending counter, both clocked. This lets the pipeline depth to write-back (WB_DIST) and the flag latency (FLAG_LAT) be configured, and lets a memory-wait hold freeze the hazard state. It sits beside the decode stage and drives the PC, IF/ID and ID/EX stall and flush controls.

## Interface
- REG_W, 4: register-ID width; 2**REG_W registers tracked, register 0 never tracked.
- WB_DIST, 2: cycles from ID issue until the result is visible to an ID-stage register-file read (write-through bypass). Must be ≥1.
- FLAG_LAT, 1: cycles from issue of a flag-setting instruction until its flags are usable by a branch in ID. Must be ≥1.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- pipe_hold  in  1  memory wait; freezes the whole pipeline and the scoreboard.
- id_valid  in  1  ID holds a real instruction (0 = bubble).
- id_rs, id_rt  in  REG_W  source register IDs in ID.
- id_rs_used, id_rt_used  in  1  the corresponding source is actually read.
- id_rd  in  REG_W  destination register ID of the ID instruction.
- id_reg_write  in  1  ID instruction writes id_rd.
- id_mem_read  in  1  ID instruction is a load.
- id_mem_write  in  1  ID instruction is a store; id_rt is the store data.
- id_flag_en  in  1  ID instruction sets any of Z/N/V.
- id_branch  in  1  conditional branch (B or BR) in ID.
- id_br  in  1  register-target branch (BR) in ID; qualified by id_branch.
- id_hlt  in  1  halt in ID.
- update_pc  in  1  PC redirect resolved this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- id_flush  out  1  inject a bubble into ID/EX.
- if_flush  out  1  squash the IF/ID instruction word.
- perf_lu_cnt, perf_br_cnt  out  32  stall-cycle counters (see Configuration).

## Operation
- State: cnt[r] (width clog2(WB_DIST+1)) and ld[r] for r = 1..2**REG_W-1; flag_cnt (width clog2(FLAG_LAT+1)).
- issue = id_valid & ~if_id_stall & ~pipe_hold.
- Hazards, evaluated combinationally from state and ID inputs, all gated by id_valid:
  - lu_haz: a used source r has ld[r] & cnt[r]==WB_DIST, meaning a load is in EX. id_rt does not raise lu_haz when id_mem_write=1, because MEM-MEM forwarding covers store data.
  - fl_haz: id_branch & flag_cnt!=0.
  - br_haz: id_branch & id_br & cnt[id_rs]!=0, for id_rs≠0.
- Outputs when pipe_hold=1: pc_stall=if_id_stall=1, id_flush=0, if_flush=0.
- Outputs when pipe_hold=0:
  - if_id_stall = pc_stall = id_hlt | lu_haz | fl_haz | br_haz.
  - id_flush = lu_haz | fl_haz | br_haz. A halt alone does not flush.
  - if_flush = update_pc & ~if_id_stall.
- Sequential update, skipped entirely while pipe_hold=1:
  - Every nonzero cnt[r] and flag_cnt decrements by 1. ld[r] clears when cnt[r] reaches 0.
  - On issue with id_reg_write and id_rd≠0: cnt[id_rd] ← WB_DIST and ld[id_rd] ← id_mem_read. This load overrides that register's decrement; a newer writer always overwrites an older one.
  - On issue with id_flag_en: flag_cnt ← FLAG_LAT.
  - id_rd=0 is never recorded. A flushed slot or a bubble records nothing.

## Timing
- Reset: all cnt, ld and flag_cnt are 0. All stall and flush outputs are 0 in the first cycle after reset, unless ID inputs raise a hazard (for example id_hlt). Both perf counters are 0.
- Stall and flush outputs are combinational: same cycle as the ID inputs, zero latency.
- ALU writer issued at edge t, dependent BR in ID: stalls for WB_DIST cycles, then proceeds on the WB_DIST+1-th ID cycle.
- Load writer followed by a dependent ALU consumer: exactly 1 stall cycle, independent of WB_DIST.
- Flag setter followed by a branch: FLAG_LAT stall cycles.
- pipe_hold mid-hazard: remaining stall cycles are preserved. Counters resume from their frozen values.
- rst asserted mid-stall: the scoreboard clears at that edge and pending hazards are discarded.

## Configuration
- HAZ_PERF_CNT_EN defined: perf_lu_cnt increments on each cycle with lu_haz & ~pipe_hold. perf_br_cnt increments on each cycle with (fl_haz | br_haz) & ~pipe_hold. Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by rst.
- HAZ_PERF_CNT_EN undefined: the counters are not built and both ports are tied to 32'h0. All other behaviour is identical.

## Test plan
- Load-use: issue LW r3, then ADD with id_rs=3 → 1 cycle of if_id_stall=pc_stall=id_flush=1, then released. Same case with SW id_rt=3 (store data) → no stall.
- BR dependency (WB_DIST=2): issue ADD r5, then BR with id_rs=5 → stall for 2 cycles, released on the 3rd. Repeat with WB_DIST=3 → 3 stall cycles.
- Flags: issue an id_flag_en instruction, then B → 1 stall cycle. With FLAG_LAT=2 → 2 stall cycles. B with no prior flag setter → no stall.
- pipe_hold: assert for 4 cycles in the middle of the BR stall → stall persists and id_flush=0 while held. After release the remaining stall count is unchanged.
- Redirect/halt: update_pc=1 with no hazard → if_flush=1. update_pc=1 during lu_haz → if_flush=0. id_hlt=1 → if_id_stall=1, id_flush=0. rst during a stall → all outputs 0 on the next cycle.
- With HAZ_PERF_CNT_EN defined: run 3 load-use stalls and 2 BR stalls → perf_lu_cnt=3, perf_br_cnt=2. Undefined → both read 0.
